// File: rtl/chunked_subtractor_if.sv
// Operand/result handshake bundle for chunked_subtractor: operands flow master->slave,
// result and flags flow back; both directions use valid/ready.
interface chunked_subtractor_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  borrow_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow_out;
  logic                  zero;
  logic                  negative;
  logic                  overflow;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, zero, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, zero, negative, overflow
  );
endinterface

// File: rtl/chunked_subtractor.sv
// Multi-cycle A - B - Bin, CHUNK_WIDTH bits per clock; result valid DATA_WIDTH/CHUNK_WIDTH clocks after accept.
// One operation in flight: in_ready only in IDLE, result held indefinitely while out_ready is low.
module chunked_subtractor #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHUNK_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  chunked_subtractor_if.slave bus
);
  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((CHUNK_WIDTH < 1) || (DATA_WIDTH < 1) || ((DATA_WIDTH % CHUNK_WIDTH) != 0)) begin : g_param_check
      $error("chunked_subtractor: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  borrow_q, borrow_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic                  a_msb_q, a_msb_d;
  logic                  b_msb_q, b_msb_d;
  logic                  borrow_out_q, borrow_out_d;
  logic                  zero_q, zero_d;
  logic                  negative_q, negative_d;
  logic                  overflow_q, overflow_d;

  // Operands shift right each chunk, so the active chunk is always the low slice;
  // the extra top bit of the chunk subtract is the borrow into the next chunk.
  logic [CHUNK_WIDTH:0] chunk_sub;
  assign chunk_sub = {1'b0, a_q[CHUNK_WIDTH-1:0]}
                   - {1'b0, b_q[CHUNK_WIDTH-1:0]}
                   - {{CHUNK_WIDTH{1'b0}}, borrow_q};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    negative_d   = negative_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.borrow_in;
          a_msb_d  = bus.a[DATA_WIDTH-1];
          b_msb_d  = bus.b[DATA_WIDTH-1];
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> CHUNK_WIDTH;
        b_d      = b_q >> CHUNK_WIDTH;
        diff_d   = (diff_q >> CHUNK_WIDTH)
                 | (DATA_WIDTH'(chunk_sub[CHUNK_WIDTH-1:0]) << (DATA_WIDTH - CHUNK_WIDTH));
        borrow_d = chunk_sub[CHUNK_WIDTH];
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          borrow_out_d = chunk_sub[CHUNK_WIDTH];
          zero_d       = (diff_d == '0);
          negative_d   = diff_d[DATA_WIDTH-1];
          overflow_d   = (a_msb_q != b_msb_q) && (diff_d[DATA_WIDTH-1] != a_msb_q);
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      negative_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      negative_q   <= negative_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.zero       = zero_q;
  assign bus.negative   = negative_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_chunked_subtractor.sv
// Bench for chunked_subtractor: five width/chunk configurations side by side, an arithmetic
// reference model checked every cycle, plus literal expectations for the directed vectors.
module tb_chunked_subtractor;
  localparam int NC = 5;
  localparam int DW_T [NC] = '{8, 8, 8, 8, 32};
  localparam int CW_T [NC] = '{2, 1, 4, 8, 8};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC-1:0]       iv, ibin, ordy, ir, ov, o_bo, o_z, o_neg, o_ovf;
  logic [NC-1:0][31:0] ia, ib, od;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          pend  [NC];
  int          cnt   [NC];
  logic [31:0] e_d   [NC];
  logic        e_bo  [NC];
  logic        e_z   [NC];
  logic        e_n   [NC];
  logic        e_o   [NC];

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    chunked_subtractor_if #(.DATA_WIDTH(DW_T[g])) bus ();
    chunked_subtractor #(.DATA_WIDTH(DW_T[g]), .CHUNK_WIDTH(CW_T[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign bus.in_valid  = iv[g];
    assign bus.a         = ia[g][DW_T[g]-1:0];
    assign bus.b         = ib[g][DW_T[g]-1:0];
    assign bus.borrow_in = ibin[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]    = bus.in_ready;
    assign ov[g]    = bus.out_valid;
    assign od[g]    = 32'(bus.diff);
    assign o_bo[g]  = bus.borrow_out;
    assign o_z[g]   = bus.zero;
    assign o_neg[g] = bus.negative;
    assign o_ovf[g] = bus.overflow;
  end

  function automatic int lat_n(input int c);
    return DW_T[c] / CW_T[c];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: difference, unsigned borrow and true signed-range overflow.
  function automatic void model_calc(input int dw, input logic [31:0] a, input logic [31:0] b,
                                     input logic bin, output logic [31:0] d, output logic bo,
                                     output logic z, output logic n, output logic o);
    longint m    = (longint'(1) << dw) - 1;
    longint half = longint'(1) << (dw - 1);
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint r    = ua - ub - longint'(bin);
    longint sa   = (ua >= half) ? ua - 2 * half : ua;
    longint sb   = (ub >= half) ? ub - 2 * half : ub;
    longint sr   = sa - sb - longint'(bin);
    d  = 32'(r & m);
    bo = (r < 0);
    z  = ((r & m) == 0);
    n  = d[dw-1];
    o  = (sr < -half) || (sr >= half);
  endfunction

  task automatic model_update();
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        pend[c] = 1'b0;
      end else if (pend[c] && cnt[c] >= lat_n(c) && ordy[c]) begin
        pend[c] = 1'b0;
      end else if (!pend[c] && iv[c]) begin
        pend[c] = 1'b1;
        cnt[c]  = 0;
        model_calc(DW_T[c], ia[c], ib[c], ibin[c], e_d[c], e_bo[c], e_z[c], e_n[c], e_o[c]);
      end else if (pend[c] && cnt[c] < lat_n(c)) begin
        cnt[c]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      logic exp_ov;
      exp_ov = pend[c] && (cnt[c] >= lat_n(c));
      chk($sformatf("c%0d in_ready", c), 32'(ir[c]), 32'(!pend[c]));
      chk($sformatf("c%0d out_valid", c), 32'(ov[c]), 32'(exp_ov));
      if (exp_ov) begin
        chk($sformatf("c%0d diff", c), od[c], e_d[c]);
        chk($sformatf("c%0d borrow_out", c), 32'(o_bo[c]), 32'(e_bo[c]));
        chk($sformatf("c%0d zero", c), 32'(o_z[c]), 32'(e_z[c]));
        chk($sformatf("c%0d negative", c), 32'(o_neg[c]), 32'(e_n[c]));
        chk($sformatf("c%0d overflow", c), 32'(o_ovf[c]), 32'(e_o[c]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Drives one operation; hold>0 keeps out_ready low that many cycles with in_valid hammering.
  task automatic run_op(input int c, input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input int hold, output logic [31:0] d, output logic bo, output logic z,
                        output logic n, output logic o);
    int lat;
    iv[c] = 1'b1; ia[c] = a; ib[c] = b; ibin[c] = bin;
    tick();
    iv[c] = 1'b0; ia[c] = $urandom; ib[c] = $urandom; ibin[c] = ~bin;
    lat = 0;
    while (!ov[c] && lat < 200) begin
      if (hold > 0) iv[c] = 1'b1;
      tick();
      lat++;
    end
    chk($sformatf("c%0d latency", c), 32'(lat), 32'(lat_n(c)));
    d = od[c]; bo = o_bo[c]; z = o_z[c]; n = o_neg[c]; o = o_ovf[c];
    for (int i = 0; i < hold; i++) begin
      iv[c] = 1'b1;
      tick();
      chk("hold in_ready", 32'(ir[c]), 32'd0);
      chk("hold diff", od[c], d);
      chk("hold flags", {28'd0, o_bo[c], o_z[c], o_neg[c], o_ovf[c]}, {28'd0, bo, z, n, o});
    end
    iv[c] = 1'b0;
    ordy[c] = 1'b1;
    tick();
    ordy[c] = 1'b0;
    chk($sformatf("c%0d in_ready after handshake", c), 32'(ir[c]), 32'd1);
  endtask

  task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input logic bin, input int hold,
                           input logic [31:0] ed, input logic [3:0] eflags);
    logic [31:0] d;
    logic bo, z, n, o;
    run_op(0, a, b, bin, hold, d, bo, z, n, o);
    chk($sformatf("lit %0h-%0h-%0d diff", a, b, bin), d, ed);
    chk($sformatf("lit %0h-%0h-%0d flags{bo,z,n,o}", a, b, bin), {28'd0, bo, z, n, o}, {28'd0, eflags});
  endtask

  logic [31:0] edge_a [4] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h7F7F7F7F};
  logic [31:0] edge_b [4] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80808080};
  logic        edge_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [31:0] d;
    logic bo, z, n, o;
    rst = 1'b1; iv = '0; ibin = '0; ordy = '0; ia = '0; ib = '0;
    tick();
    tick();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("c%0d reset in_ready", c), 32'(ir[c]), 32'd1);
      chk($sformatf("c%0d reset out_valid", c), 32'(ov[c]), 32'd0);
      chk($sformatf("c%0d reset diff", c), od[c], 32'd0);
      chk($sformatf("c%0d reset flags", c), {28'd0, o_bo[c], o_z[c], o_neg[c], o_ovf[c]}, 32'd0);
    end
    rst = 1'b0;
    tick();

    // flags packed as {borrow_out, zero, negative, overflow}
    expect_op(32'h50, 32'h30, 1'b0, 0, 32'h20, 4'b0000);
    expect_op(32'h00, 32'h01, 1'b0, 0, 32'hFF, 4'b1010);
    expect_op(32'h80, 32'h01, 1'b0, 0, 32'h7F, 4'b0001);
    expect_op(32'h05, 32'h04, 1'b1, 0, 32'h00, 4'b0100);
    expect_op(32'h00, 32'hFF, 1'b1, 0, 32'h00, 4'b1100);
    expect_op(32'h50, 32'h30, 1'b0, 10, 32'h20, 4'b0000);

    // reset two chunks into a run: partial work is dropped
    iv[0] = 1'b1; ia[0] = 32'hA5; ib[0] = 32'h3C; ibin[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", 32'(ir[0]), 32'd1);
    chk("abort out_valid", 32'(ov[0]), 32'd0);
    chk("abort diff", od[0], 32'd0);
    chk("abort flags", {28'd0, o_bo[0], o_z[0], o_neg[0], o_ovf[0]}, 32'd0);
    expect_op(32'h50, 32'h30, 1'b0, 0, 32'h20, 4'b0000);

    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 4; k++) run_op(c, edge_a[k], edge_b[k], edge_c[k], 0, d, bo, z, n, o);
      for (int k = 0; k < 10; k++) run_op(c, $urandom, $urandom, 1'($urandom), k % 3, d, bo, z, n, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
